// File: rtl/usb_gpx_conditioner_if.sv
// Avalon-MM register port of the GPX conditioner.
// The CPU side uses master; the conditioner uses slave.
interface usb_gpx_conditioner_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/usb_gpx_conditioner.sv
// GPX line conditioner: synchronize, debounce, edge capture/count, masked level irq.
// Latency: pin to gpx_filtered FILTER_CYCLES+2 clk; readdata 1 clk; irq 1 clk after capture/mask.
// Backpressure: none, the register port has no waitrequest and accepts every access.
module usb_gpx_conditioner #(
    parameter int FILTER_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  gpx_pin,
    usb_gpx_conditioner_if.slave  bus,
    output logic                  gpx_filtered,
    output logic                  irq
);
    typedef enum logic [1:0] {LOW, RISE_QUAL, HIGH, FALL_QUAL} state_t;

    localparam logic [7:0] QMAX = 8'(FILTER_CYCLES - 1);

    logic             sync1, sync_q;
    state_t           state, state_n;
    logic [7:0]       qcnt, qcnt_n;
    logic             filt, filt_n, filt_d;
    logic             rise_p, fall_p;
    logic [1:0]       cap, mask;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rd_mux, rdata;
    logic             wr_cap, wr_mask, wr_cnt;
    logic             unused_bits;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync_q <= 1'b0;
            state  <= LOW;
            qcnt   <= '0;
            filt   <= 1'b0;
        end else begin
            sync1  <= gpx_pin;
            sync_q <= sync1;
            state  <= state_n;
            qcnt   <= qcnt_n;
            filt   <= filt_n;
        end
    end

    // A qualify state falls back as soon as one sample disagrees.
    always_comb begin
        state_n = state;
        qcnt_n  = qcnt;
        filt_n  = filt;
        case (state)
            LOW: begin
                if (sync_q) begin
                    state_n = RISE_QUAL;
                    qcnt_n  = 8'd1;
                end else begin
                    qcnt_n  = '0;
                end
            end
            RISE_QUAL: begin
                if (!sync_q) begin
                    state_n = LOW;
                    qcnt_n  = '0;
                end else if (qcnt == QMAX) begin
                    state_n = HIGH;
                    qcnt_n  = '0;
                    filt_n  = 1'b1;
                end else begin
                    qcnt_n  = qcnt + 8'd1;
                end
            end
            HIGH: begin
                if (!sync_q) begin
                    state_n = FALL_QUAL;
                    qcnt_n  = 8'd1;
                end else begin
                    qcnt_n  = '0;
                end
            end
            FALL_QUAL: begin
                if (sync_q) begin
                    state_n = HIGH;
                    qcnt_n  = '0;
                end else if (qcnt == QMAX) begin
                    state_n = LOW;
                    qcnt_n  = '0;
                    filt_n  = 1'b0;
                end else begin
                    qcnt_n  = qcnt + 8'd1;
                end
            end
            default: begin
                state_n = LOW;
                qcnt_n  = '0;
                filt_n  = 1'b0;
            end
        endcase
    end

    assign wr_cap  = bus.write && (bus.address == 2'd1);
    assign wr_mask = bus.write && (bus.address == 2'd2);
    assign wr_cnt  = bus.write && (bus.address == 2'd3);

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux = {30'd0, sync_q, filt};
            2'd1:    rd_mux = {30'd0, cap};
            2'd2:    rd_mux = {30'd0, mask};
            default: rd_mux = 32'(cnt);
        endcase
    end

    // Capture set terms are OR-ed after the clear so a new edge is never lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_d <= 1'b0;
            rise_p <= 1'b0;
            fall_p <= 1'b0;
            cap    <= '0;
            mask   <= '0;
            cnt    <= '0;
            rdata  <= '0;
            irq    <= 1'b0;
        end else begin
            filt_d <= filt;
            rise_p <= filt & ~filt_d;
            fall_p <= ~filt & filt_d;
            cap[0] <= rise_p | (cap[0] & ~(wr_cap & bus.writedata[0]));
            cap[1] <= fall_p | (cap[1] & ~(wr_cap & bus.writedata[1]));
            if (wr_mask) begin
                mask <= bus.writedata[1:0];
            end
            if (wr_cnt) begin
                cnt <= rise_p ? CNT_W'(1) : '0;
            end else if (rise_p && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
            rdata  <= rd_mux;
            irq    <= |(cap & mask);
        end
    end

    assign bus.readdata = rdata;
    assign gpx_filtered = filt;
    assign unused_bits  = ^{bus.read, bus.writedata[31:2]};
endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Randomized bench for usb_gpx_conditioner against a cycle-level behavioural model.
module tb_usb_gpx_conditioner;
    localparam int F       = 8;
    localparam int W       = 4;
    localparam int CNT_MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    logic gpx_pin;
    logic gpx_filtered;
    logic irq;

    usb_gpx_conditioner_if bus();

    always #5 clk = ~clk;

    usb_gpx_conditioner #(.FILTER_CYCLES(F), .CNT_W(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gpx_pin      (gpx_pin),
        .bus          (bus),
        .gpx_filtered (gpx_filtered),
        .irq          (irq)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Model: filtered flips once F consecutive synchronized samples disagree with it.
    bit          m_s1, m_s2, m_filt, m_filt_d, m_rise, m_fall, m_irq;
    bit [1:0]    m_cap, m_mask;
    int          m_run, m_cnt;
    logic [31:0] m_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          wr1, wr2, wr3, n_filt, n_irq;
        bit [1:0]    n_cap;
        int          n_cnt, n_run;
        logic [31:0] n_rd;
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_filt_d = 0; m_rise = 0; m_fall = 0;
            m_irq = 0; m_cap = 0; m_mask = 0; m_run = 0; m_cnt = 0; m_rd = '0;
            return;
        end
        wr1 = bus.write && bus.address == 2'd1;
        wr2 = bus.write && bus.address == 2'd2;
        wr3 = bus.write && bus.address == 2'd3;
        case (bus.address)
            2'd0:    n_rd = {30'd0, m_s2, m_filt};
            2'd1:    n_rd = {30'd0, m_cap};
            2'd2:    n_rd = {30'd0, m_mask};
            default: n_rd = 32'(m_cnt);
        endcase
        n_irq    = |(m_cap & m_mask);
        n_cap[0] = m_rise | (m_cap[0] & !(wr1 && bus.writedata[0]));
        n_cap[1] = m_fall | (m_cap[1] & !(wr1 && bus.writedata[1]));
        if (wr3)                            n_cnt = m_rise ? 1 : 0;
        else if (m_rise && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
        else                                n_cnt = m_cnt;
        n_filt = m_filt;
        n_run  = 0;
        if (m_s2 != m_filt) begin
            n_run = m_run + 1;
            if (n_run == F) begin
                n_filt = !m_filt;
                n_run  = 0;
            end
        end
        m_rise   = m_filt & !m_filt_d;
        m_fall   = !m_filt & m_filt_d;
        m_filt_d = m_filt;
        m_filt   = n_filt;
        m_run    = n_run;
        m_s2     = m_s1;
        m_s1     = gpx_pin;
        if (wr2) m_mask = bus.writedata[1:0];
        m_cap = n_cap;
        m_cnt = n_cnt;
        m_rd  = n_rd;
        m_irq = n_irq;
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        if (chk_en) begin
            check("cyc_filtered", gpx_filtered, m_filt);
            check("cyc_irq", irq, m_irq);
            check("cyc_readdata", bus.readdata, m_rd);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.write = 1'b1; bus.writedata = d;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1;
        @(posedge clk);
        #2;
        v = bus.readdata;
        bus.read = 1'b0;
    endtask

    // Caller changes the pin on a negedge; the level must land on exactly the 10th posedge.
    task automatic expect_edge(input string name, input logic lvl);
        for (int i = 1; i <= F + 2; i++) begin
            @(posedge clk);
            #2;
            if (i == F + 1) check({name, "_early"}, gpx_filtered, !lvl);
            if (i == F + 2) check(name, gpx_filtered, lvl);
        end
    endtask

    initial begin
        #2ms;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int hold;
        bus.address = 0; bus.read = 0; bus.write = 0; bus.writedata = 0;
        reset_n = 1'b0; gpx_pin = 1'b0;
        wait_cycles(3);
        chk_en = 1;
        check("rst_filtered", gpx_filtered, 0);
        check("rst_irq", irq, 0);
        check("rst_readdata", bus.readdata, 0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("rst_reg", v, 0);
        end

        // Qualified rise and fall
        @(negedge clk); gpx_pin = 1'b1;
        expect_edge("rise_latency", 1'b1);
        wait_cycles(4);
        rd(2'd1, v); check("rise_capture", v, 32'h1);
        rd(2'd3, v); check("rise_count", v, 32'h1);
        rd(2'd0, v); check("reg0_high", v, 32'h3);
        wr(2'd0, 32'h0);
        rd(2'd0, v); check("reg0_ro", v, 32'h3);
        wr(2'd1, 32'h1);
        rd(2'd1, v); check("w1c_bit0", v, 32'h0);
        @(negedge clk); gpx_pin = 1'b0;
        expect_edge("fall_latency", 1'b0);
        wait_cycles(4);
        rd(2'd1, v); check("fall_capture", v, 32'h2);
        wr(2'd1, 32'h3);

        // Glitches shorter than the filter
        wr(2'd3, 32'h0);
        @(negedge clk); gpx_pin = 1'b1;
        wait_cycles(5);
        gpx_pin = 1'b0;
        wait_cycles(20);
        gpx_pin = 1'b1;
        wait_cycles(F - 1);
        gpx_pin = 1'b0;
        wait_cycles(20);
        rd(2'd0, v); check("glitch_reg0", v, 32'h0);
        rd(2'd1, v); check("glitch_capture", v, 32'h0);
        rd(2'd3, v); check("glitch_count", v, 32'h0);

        // irq on masked fall capture
        wr(2'd2, 32'h2);
        rd(2'd2, v); check("mask_rb", v, 32'h2);
        @(negedge clk); gpx_pin = 1'b1;
        wait_cycles(15);
        check("irq_after_rise", irq, 0);
        @(negedge clk); gpx_pin = 1'b0;
        wait_cycles(16);
        check("irq_after_fall", irq, 1);
        wr(2'd1, 32'h2);
        @(posedge clk); #2;
        check("irq_cleared", irq, 0);
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h0);

        // Clear collides with rise_p
        @(negedge clk); gpx_pin = 1'b1;
        wait_cycles(11);
        bus.address = 2'd1; bus.write = 1'b1; bus.writedata = 32'h1;
        @(negedge clk); bus.write = 1'b0;
        rd(2'd1, v); check("set_beats_clear", v, 32'h1);
        @(negedge clk); gpx_pin = 1'b0;
        wait_cycles(14);
        wr(2'd1, 32'h3);
        @(negedge clk); gpx_pin = 1'b1;
        wait_cycles(11);
        bus.address = 2'd3; bus.write = 1'b1; bus.writedata = 32'h0;
        @(negedge clk); bus.write = 1'b0;
        rd(2'd3, v); check("cnt_clear_with_rise", v, 32'h1);

        // Counter saturation
        @(negedge clk); gpx_pin = 1'b0;
        wait_cycles(14);
        wr(2'd3, 32'h0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); gpx_pin = 1'b1;
            wait_cycles(12);
            gpx_pin = 1'b0;
            wait_cycles(12);
        end
        rd(2'd3, v); check("cnt_saturated", v, 32'hF);
        check("model_cnt_saturated", 32'(m_cnt), 32'hF);
        wr(2'd3, 32'h5);
        rd(2'd3, v); check("cnt_write_clears", v, 32'h0);

        // Reset in the middle of a rise qualification
        @(negedge clk); gpx_pin = 1'b1;
        wait_cycles(7);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midq_rst_filtered", gpx_filtered, 0);
        check("midq_rst_irq", irq, 0);
        check("midq_rst_readdata", bus.readdata, 0);
        @(negedge clk); reset_n = 1'b1;
        expect_edge("requal_latency", 1'b1);

        // Random traffic
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                gpx_pin = 1'($urandom_range(0, 1));
                hold    = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            bus.address   = 2'($urandom_range(0, 3));
            bus.read      = 1'($urandom_range(0, 1));
            bus.write     = ($urandom_range(0, 5) == 0);
            bus.writedata = $urandom;
            reset_n       = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        bus.write = 1'b0; reset_n = 1'b1;
        wait_cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_gpx_conditioner.md
USB_GPX_CONDITIONER -- requirements
Module: usb_gpx_conditioner

Interface
REQ-001 Parameter FILTER_CYCLES, default 8, consecutive synchronized samples required to accept a level change (legal 2..255).
REQ-002 Parameter CNT_W, default 16, width of the rising-edge event counter.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 gpx_pin  in  1  asynchronous GPX line from the USB host controller.
REQ-006 address  in  2  Avalon-MM word address.
REQ-007 read  in  1  Avalon-MM read strobe.
REQ-008 write  in  1  Avalon-MM write strobe.
REQ-009 writedata  in  32  Avalon-MM write data.
REQ-010 readdata  out  32  Avalon-MM read data, registered.
REQ-011 gpx_filtered  out  1  debounced GPX level; drives the downstream GPX PIO input port.
REQ-012 irq  out  1  level interrupt, registered.

Function
REQ-013 gpx_pin passes through a 2-flop synchronizer; sync_q is the second flop output.
REQ-014 Filter FSM states: LOW, RISE_QUAL, HIGH, FALL_QUAL; counter qcnt is 8 bits.
REQ-015 LOW: sync_q=1 -> RISE_QUAL, qcnt=1; otherwise stay, qcnt=0.
REQ-016 RISE_QUAL: sync_q=0 -> LOW, qcnt=0; sync_q=1 and qcnt=FILTER_CYCLES-1 -> HIGH, gpx_filtered=1; otherwise qcnt+1.
REQ-017 HIGH/FALL_QUAL mirror REQ-015/016 with polarity inverted; reaching FILTER_CYCLES zeros -> LOW, gpx_filtered=0.
REQ-018 Glitch of fewer than FILTER_CYCLES synchronized cycles produces no change on gpx_filtered.
REQ-019 Latency pin change to gpx_filtered change = FILTER_CYCLES+2 clk cycles.
REQ-020 Internal rise_p/fall_p one-cycle pulses are asserted in the cycle after gpx_filtered changes 0->1 / 1->0.
REQ-021 Register 0 (RO): bit0 gpx_filtered, bit1 sync_q, other bits 0.
REQ-022 Register 1 (edge capture): bit0 set by rise_p, bit1 set by fall_p; write-1-to-clear per bit; set wins over clear in the same cycle.
REQ-023 Register 2 (R/W): irq mask bits [1:0]; other bits read 0.
REQ-024 Register 3: rising-edge counter, zero-extended to 32 bits; increments on rise_p and saturates at 2^CNT_W-1; any write clears it; write and rise_p in the same cycle -> value 1.
REQ-025 readdata updates on every clk edge with the register selected by address; read latency 1 cycle; read has no side effects.
REQ-026 Writes to register 0 are ignored.
REQ-027 irq is computed one cycle after capture/mask as |(capture[1:0] & mask[1:0]).

Reset
REQ-028 On reset_n=0 at a clk edge: synchronizer flops 0, FSM=LOW, qcnt=0, gpx_filtered=0, capture=0, mask=0, counter=0, readdata=0, irq=0.
REQ-029 Reset mid-qualification abandons the qualification; after release, a high pin requires the full FILTER_CYCLES+2 cycles again.
REQ-030 Nothing is asynchronous to clk other than gpx_pin.

Verification
REQ-031 Pin 0->1 held, FILTER_CYCLES=8 -> gpx_filtered high exactly 10 cycles later; capture=0x1; counter=1.
REQ-032 Pin 1-pulse of 5 cycles from LOW -> gpx_filtered stays 0; capture=0; counter=0.
REQ-033 mask=0x2, rise then fall -> irq low after rise, high 1 cycle after the fall capture; write 0x2 to reg1 -> irq low next cycle.
REQ-034 Write 0x1 to reg1 in the same cycle as rise_p -> capture bit0 remains 1.
REQ-035 CNT_W=4, 17 qualified rising edges -> reg3 reads 0xF; write to reg3 -> reads 0.
REQ-036 reset_n low during RISE_QUAL at qcnt=5 -> all outputs 0; pin held high -> gpx_filtered rises 10 cycles after reset release.
